// File: rtl/alu_lockstep_bist.sv
`default_nettype none
// ============================================================================
// Module      : alu_lockstep_bist
// Description : Self-test sequencer for the dual-ALU lockstep XOR checker.
//               Sweeps all 1024 {sel, A, B} vectors into both ALU copies and
//               records mismatches. Optional ALU_BIST_FAULT_INJECT_EN adds a
//               copy-2 operand corruption port pair for checker self-test.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_lockstep_bist #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef ALU_BIST_FAULT_INJECT_EN
  input  logic                 inject_en,
  input  logic [9:0]           inject_vec,
`endif
  input  logic [3:0]           x,
  input  logic                 y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [3:0]           A0,
  output logic [3:0]           B0,
  output logic [3:0]           A1,
  output logic [3:0]           B1,
  output logic [1:0]           ALU_Sel1,
  output logic [1:0]           ALU_Sel2,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [9:0]           first_fail_vec,
  output logic                 first_fail_valid
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [9:0] c_LAST_VEC    = 10'd1023;

  state_t                 r_state;
  state_t                 w_next;
  logic [9:0]             r_vec;
  logic [3:0]             r_settle;
  logic [3:0]             r_a;
  logic [3:0]             r_b0;
  logic [3:0]             r_b1;
  logic [1:0]             r_sel;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic [ERR_CNT_W-1:0]   r_err;
  logic [9:0]             r_ffv;
  logic                   r_ffvalid;
  logic                   w_mismatch;
  logic                   w_inject;

  assign w_mismatch = (|x) | y;

`ifdef ALU_BIST_FAULT_INJECT_EN
  assign w_inject = inject_en && (r_vec == inject_vec);
`else
  assign w_inject = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_DRIVE;
      S_DRIVE:  w_next = S_SETTLE;
      S_SETTLE: if (r_settle == 4'd0) w_next = S_CHECK;
      S_CHECK:  w_next = (r_vec == c_LAST_VEC) ? S_FINISH : S_DRIVE;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec     <= '0;
      r_settle  <= '0;
      r_a       <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_ffv     <= '0;
      r_ffvalid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err     <= '0;
            r_ffv     <= '0;
            r_ffvalid <= 1'b0;
            r_pass    <= 1'b0;
            r_vec     <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_DRIVE: begin
          r_sel    <= r_vec[9:8];
          r_a      <= r_vec[7:4];
          r_b0     <= r_vec[3:0];
          r_b1     <= r_vec[3:0] ^ {3'b000, w_inject};
          r_settle <= c_SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            if (!(&r_err)) r_err <= r_err + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            if (!r_ffvalid) begin
              r_ffv     <= r_vec;
              r_ffvalid <= 1'b1;
            end
          end
          if (r_vec != c_LAST_VEC) r_vec <= r_vec + 10'd1;
        end
        S_FINISH: begin
          // err_count already reflects the final CHECK update here
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_pass <= (r_err == '0);
          r_sel  <= '0;
          r_a    <= '0;
          r_b0   <= '0;
          r_b1   <= '0;
          r_vec  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign A0               = r_a;
  assign A1               = r_a;
  assign B0               = r_b0;
  assign B1               = r_b1;
  assign ALU_Sel1         = r_sel;
  assign ALU_Sel2         = r_sel;
  assign err_count        = r_err;
  assign first_fail_vec   = r_ffv;
  assign first_fail_valid = r_ffvalid;

endmodule
`default_nettype wire
